// File: rtl/kbd_spi_rx.sv
// Keyboard matrix receiver: 48-bit SPI frames from the PS/2 controller into a row/column matrix.
// Optional KBD_TIMEOUT_EN clears a stale matrix after 2**TIMEOUT_LOG2-1 cycles with no commit.
module kbd_spi_rx #(
  parameter int FRAME_BITS   = 48,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_LOG2 = 20
) (
  input  logic       CLK_14MHZ,
  input  logic       RESET,
  input  logic       KBD_CLK,
  input  logic       KBD_CS,
  input  logic       KBD_DI,
  input  logic [7:0] A_HI,
  output logic [4:0] KEYS,
  output logic [7:0] EXT_KEYS,
  output logic       MATRIX_VALID,
  output logic       FRAME_STB,
  output logic       FRAME_ERR
);

  // state   | meaning
  // S_IDLE  | waiting for a CS fall, bit counter held at zero
  // S_SHIFT | collecting bits on SCK rises until CS rises
  // S_DRAIN | frame overran, discarding everything until CS rises
  // S_COMMIT| one cycle: copy shift register into matrix and flags

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_COMMIT} state_t;

  localparam logic [5:0] FRAME_N = 6'(FRAME_BITS);

  if (SYNC_STAGES < 2 || TIMEOUT_LOG2 < 2) begin : g_param_check
    $error("kbd_spi_rx: SYNC_STAGES and TIMEOUT_LOG2 must both be at least 2");
  end

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, di_sync, fill;
  logic                   sck_prev, cs_prev, armed;
  logic                   sck_s, cs_s, di_s;
  logic                   sck_rise, cs_rise, cs_fall;

  state_t                 state, state_n;
  logic [5:0]             bitcnt, bitcnt_n;
  logic [FRAME_BITS-1:0]  sr, sr_n;
  logic                   err_n, err_q;
  logic [39:0]            matrix;
  logic [4:0]             pressed;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign di_s  = di_sync[SYNC_STAGES-1];

  // A CS fall is only trusted once CS has been seen high through a fully
  // refilled synchronizer, so a frame already running at reset release is skipped.
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = armed & ~cs_s & cs_prev;

  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      sck_sync <= '1;
      cs_sync  <= '1;
      di_sync  <= '1;
      sck_prev <= 1'b1;
      cs_prev  <= 1'b1;
      fill     <= '0;
      armed    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], KBD_CLK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], KBD_CS};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], KBD_DI};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    sr_n     = sr;
    err_n    = 1'b0;
    case (state)
      S_IDLE: begin
        bitcnt_n = '0;
        if (cs_fall) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (sck_rise) begin
          if (bitcnt < FRAME_N) begin
            sr_n     = {sr[FRAME_BITS-2:0], di_s};
            bitcnt_n = bitcnt + 6'd1;
          end else begin
            err_n   = 1'b1;
            state_n = S_DRAIN;
          end
        end
        // CS rise is judged against the count after this cycle's bit
        if (cs_rise) begin
          if (state_n == S_DRAIN) begin
            state_n = S_IDLE;
          end else if (bitcnt_n == FRAME_N) begin
            state_n = S_COMMIT;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (cs_rise) state_n = S_IDLE;
      end
      S_COMMIT: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      state  <= S_IDLE;
      bitcnt <= '0;
      sr     <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      sr     <= sr_n;
      err_q  <= err_n;
    end
  end

`ifdef KBD_TIMEOUT_EN
  localparam logic [TIMEOUT_LOG2-1:0] TO_MAX  = {TIMEOUT_LOG2{1'b1}};
  localparam logic [TIMEOUT_LOG2-1:0] TO_LAST = TO_MAX - 1'b1;
  logic [TIMEOUT_LOG2-1:0] to_cnt;

  always_ff @(posedge CLK_14MHZ) begin
    if (RESET || state == S_COMMIT) to_cnt <= '0;
    else if (to_cnt != TO_MAX)      to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK_14MHZ) begin
    if (RESET) begin
      matrix       <= '0;
      EXT_KEYS     <= '0;
      MATRIX_VALID <= 1'b0;
    end else if (state == S_COMMIT) begin
      matrix       <= sr[39:0];
      EXT_KEYS     <= sr[FRAME_BITS-1:40];
      MATRIX_VALID <= 1'b1;
    end
`ifdef KBD_TIMEOUT_EN
    else if (to_cnt == TO_LAST) begin
      matrix       <= '0;
      EXT_KEYS     <= '0;
      MATRIX_VALID <= 1'b0;
    end
`endif
  end

  assign FRAME_STB = (state == S_COMMIT);
  assign FRAME_ERR = err_q;

  always_comb begin
    pressed = '0;
    for (int r = 0; r < 8; r++) begin
      if (!A_HI[r]) pressed = pressed | matrix[5*r +: 5];
    end
    KEYS = ~pressed;
  end

endmodule
